// File: rtl/debug_uart_dumper_pkg.sv
`default_nettype none
// ============================================================================
// debug_uart_dumper_pkg
// Shared FSM encoding, ASCII constants and nibble-to-hex helper.
// Revision: 1.0
// ============================================================================
package debug_uart_dumper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_NEXT    = 3'd4
    } state_t;

    localparam logic [7:0] CR      = 8'h0D;
    localparam logic [7:0] LF      = 8'h0A;
    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_A = 8'h41;

    localparam int BYTES_PER_REG = 10;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_0 + {4'h0, nib};
        end
        return ASCII_A + {4'h0, nib} - 8'd10;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debug_uart_dumper_uart_tx.sv
`default_nettype none
// ============================================================================
// uart_tx
// 8N1 serializer; ready stays low for the whole frame and returns one cycle
// after the stop bit, so back-to-back bytes are separated by one idle cycle.
// Revision: 1.0
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       tx,
    output logic       ready
);

    localparam logic [15:0] c_baud_max = 16'(CLKS_PER_BIT - 1);

    logic [7:0]  r_shift;
    logic [3:0]  r_bit_cnt;
    logic [15:0] r_baud_cnt;

    always_ff @(posedge clk) begin
        if (RESET) begin
            tx         <= 1'b1;
            ready      <= 1'b1;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
        end else if (ready) begin
            if (valid) begin
                tx         <= 1'b0;
                ready      <= 1'b0;
                r_shift    <= data;
                r_bit_cnt  <= '0;
                r_baud_cnt <= '0;
            end
        end else if (r_baud_cnt != c_baud_max) begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
        end else begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == 4'd9) begin
                ready <= 1'b1;
            end else begin
                // Ones shift in behind the data, so bit 9 comes out as the stop bit.
                r_bit_cnt <= r_bit_cnt + 4'd1;
                tx        <= r_shift[0];
                r_shift   <= {1'b1, r_shift[7:1]};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/debug_uart_dumper.sv
`default_nettype none
// ============================================================================
// debug_uart_dumper
// Walks the register file through the debug read port and prints each entry
// over UART as eight uppercase hex digits followed by CR LF.
// Revision: 1.0
// ============================================================================
module debug_uart_dumper
    import debug_uart_dumper_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_REGS     = 16
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        start,
    output logic [3:0]  DebugSlctIn,
    input  logic [31:0] DebugOut,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int IDX_W = ($clog2(NUM_REGS + 1) > 4) ? $clog2(NUM_REGS + 1) : 4;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_REGS - 1);
    localparam logic [3:0]       c_bytes    = 4'(BYTES_PER_REG);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_shadow;
    logic [3:0]       r_byte_cnt;

    logic             w_byte_valid;
    logic             w_tx_ready;
    logic [7:0]       w_tx_data;
    logic [2:0]       w_nib_sel;
    logic [IDX_W-1:0] w_idx_inc;

    assign w_byte_valid = (r_state == ST_SEND) && (r_byte_cnt != c_bytes);
    assign w_nib_sel    = 3'd7 - r_byte_cnt[2:0];
    assign w_idx_inc    = r_idx + IDX_W'(1);

    always_comb begin
        w_tx_data = hex_ascii(r_shadow[{w_nib_sel, 2'b00} +: 4]);
        if (r_byte_cnt == 4'd8) begin
            w_tx_data = CR;
        end else if (r_byte_cnt == 4'd9) begin
            w_tx_data = LF;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk   (clk),
        .RESET (RESET),
        .data  (w_tx_data),
        .valid (w_byte_valid),
        .tx    (tx),
        .ready (w_tx_ready)
    );

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_shadow    <= '0;
            r_byte_cnt  <= '0;
            DebugSlctIn <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SELECT;
                        r_idx   <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_SELECT: begin
                    r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    r_shadow   <= DebugOut;
                    r_byte_cnt <= '0;
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    // The serializer holds its own copy of the LF byte, so the next
                    // register is fetched during that frame; only the final
                    // register waits for the line to go idle before signalling done.
                    if (r_byte_cnt == c_bytes) begin
                        if (r_idx != c_last_idx) begin
                            r_state <= ST_NEXT;
                        end else if (w_tx_ready) begin
                            r_state <= ST_NEXT;
                            done    <= 1'b1;
                        end
                    end else if (w_tx_ready) begin
                        r_byte_cnt <= r_byte_cnt + 4'd1;
                    end
                end
                ST_NEXT: begin
                    r_idx <= w_idx_inc;
                    if (r_idx == c_last_idx) begin
                        r_state     <= ST_IDLE;
                        busy        <= 1'b0;
                        DebugSlctIn <= 4'd0;
                    end else begin
                        r_state     <= ST_SELECT;
                        DebugSlctIn <= w_idx_inc[3:0];
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_debug_uart_dumper.sv
`default_nettype none
// ============================================================================
// tb_debug_uart_dumper
// Random register dumps decoded off tx and compared with a string-level model.
// Revision: 1.0
// ============================================================================
module tb_debug_uart_dumper;

    localparam int CPB  = 4;
    localparam int NREG = 16;

    logic        clk = 1'b0;
    logic        RESET;
    logic        start;
    logic [3:0]  DebugSlctIn;
    logic [31:0] DebugOut;
    logic        tx;
    logic        busy;
    logic        done;

    logic [31:0] regs [NREG];
    logic [31:0] noise  = '0;
    bit          scr_en = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    int          mon_c        = 0;
    bit          in_frame     = 1'b0;
    bit          frame_ok     = 1'b1;
    logic        mon_bit      = 1'b1;
    logic [7:0]  mon_byte     = '0;
    int          gap          = -1;
    int          started      = 0;
    int          last_end_cyc = 0;
    logic [7:0]  rx_q [$];

    debug_uart_dumper #(
        .CLKS_PER_BIT (CPB),
        .NUM_REGS     (NREG)
    ) dut (
        .clk         (clk),
        .RESET       (RESET),
        .start       (start),
        .DebugSlctIn (DebugSlctIn),
        .DebugOut    (DebugOut),
        .tx          (tx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) noise = $urandom;

    // Garbage on the read port while bytes 0..8 of a register are on the line.
    assign DebugOut = (scr_en && started > 0 && (started % 10) != 0) ? noise : regs[DebugSlctIn];

    // UART line decoder: bit stability, stop bit and inter-frame gap.
    always @(negedge clk) begin
        if (RESET) begin
            in_frame = 1'b0;
            gap      = -1;
        end else if (!in_frame) begin
            if (tx === 1'b0) begin
                if (gap >= 0) begin
                    checks++;
                    assert (gap === 1) else begin
                        errors++;
                        $error("FAIL frame_gap: got %0d idle cycles, expected 1", gap);
                    end
                end
                in_frame = 1'b1;
                mon_c    = 0;
                frame_ok = 1'b1;
                mon_bit  = 1'b0;
                started++;
            end else if (busy !== 1'b1) begin
                gap = -1;
            end else if (gap >= 0) begin
                gap++;
            end
        end else begin
            mon_c++;
            if (mon_c % CPB == 0) begin
                mon_bit = tx;
                if (mon_c / CPB <= 8) mon_byte[mon_c / CPB - 1] = tx;
            end else if (tx !== mon_bit) begin
                frame_ok = 1'b0;
            end
            if (mon_c / CPB == 9 && tx !== 1'b1) frame_ok = 1'b0;
            if (mon_c == 10 * CPB - 1) begin
                checks++;
                assert (frame_ok === 1'b1) else begin
                    errors++;
                    $error("FAIL frame_timing: frame %0d got ok=%b, expected 1", started, frame_ok);
                end
                rx_q.push_back(mon_byte);
                in_frame     = 1'b0;
                gap          = 0;
                last_end_cyc = cyc;
            end
        end
    end

    function automatic logic [79:0] expect_line(input logic [31:0] v);
        string       hexd = "0123456789ABCDEF";
        logic [79:0] r    = '0;
        for (int k = 0; k < 8; k++) begin
            r = {r[71:0], 8'(hexd[int'((v >> (28 - 4 * k)) & 32'hF)])};
        end
        r = {r[71:0], 8'h0D};
        r = {r[71:0], 8'h0A};
        return r;
    endfunction

    task automatic start_dump();
        @(negedge clk);
        #1;
        rx_q.delete();
        started = 0;
        start   = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
    endtask

    task automatic finish_dump(input bit spam, input string tag);
        int dones    = 0;
        int done_cyc = -1;
        int busy_low = 0;
        int budget   = 0;
        int extra    = 0;
        bit seen_end = 1'b0;
        while (!seen_end && budget < 9000) begin
            @(negedge clk);
            budget++;
            if (done_cyc >= 0) begin
                checks++;
                assert (done === 1'b0 && busy === 1'b0) else begin
                    errors++;
                    $error("FAIL %s_after_done: done=%b busy=%b, expected 0 0", tag, done, busy);
                end
                seen_end = 1'b1;
            end else begin
                if (busy !== 1'b1) busy_low++;
                if (done === 1'b1) begin
                    dones++;
                    done_cyc = cyc;
                end
            end
            #1;
            start = spam && (busy === 1'b1) && ((done === 1'b1) || ($urandom_range(0, 3) == 0));
        end
        start = 1'b0;
        checks++;
        assert (seen_end === 1'b1) else begin
            errors++;
            $error("FAIL %s_done_timeout: no done within %0d cycles", tag, budget);
        end
        checks++;
        assert (dones === 1) else begin
            errors++;
            $error("FAIL %s_done_count: got %0d pulses, expected 1", tag, dones);
        end
        checks++;
        assert (busy_low === 0) else begin
            errors++;
            $error("FAIL %s_busy_during_dump: got %0d low cycles, expected 0", tag, busy_low);
        end
        checks++;
        assert (done_cyc - last_end_cyc >= 1 && done_cyc - last_end_cyc <= 2) else begin
            errors++;
            $error("FAIL %s_done_latency: got %0d cycles after last stop bit, expected 1..2",
                   tag, done_cyc - last_end_cyc);
        end
        repeat (60) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        assert (extra === 0 && started === NREG * 10) else begin
            errors++;
            $error("FAIL %s_quiet_after_done: got %0d active cycles and %0d frames, expected 0 and %0d",
                   tag, extra, started, NREG * 10);
        end
        checks++;
        assert (DebugSlctIn === 4'd0) else begin
            errors++;
            $error("FAIL %s_slct_idle: got %0d, expected 0", tag, DebugSlctIn);
        end
    endtask

    task automatic compare_dump(input string tag);
        logic [79:0] got;
        logic [79:0] exp;
        checks++;
        assert (rx_q.size() === NREG * 10) else begin
            errors++;
            $error("FAIL %s_byte_count: got %0d, expected %0d", tag, rx_q.size(), NREG * 10);
        end
        for (int r = 0; r < NREG; r++) begin
            got = '0;
            for (int j = 0; j < 10; j++) begin
                got = {got[71:0], (10 * r + j < rx_q.size()) ? rx_q[10 * r + j] : 8'h00};
            end
            exp = expect_line(regs[r]);
            checks++;
            assert (got === exp) else begin
                errors++;
                $error("FAIL %s_reg%0d_text: got %h, expected %h", tag, r, got, exp);
            end
        end
    endtask

    initial begin
        string        lit = "00000000\r\nDEADBEEF\r\n";
        logic [159:0] got20;
        logic [159:0] exp20;
        int           budget;
        int           lows;
        int           dones;

        for (int i = 0; i < NREG; i++) regs[i] = '0;

        // Reset wins over a simultaneous start.
        RESET = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        assert (tx === 1'b1) else begin errors++; $error("FAIL rst_tx: got %b, expected 1", tx); end
        checks++;
        assert (busy === 1'b0) else begin errors++; $error("FAIL rst_busy: got %b, expected 0", busy); end
        checks++;
        assert (done === 1'b0) else begin errors++; $error("FAIL rst_done: got %b, expected 0", done); end
        checks++;
        assert (DebugSlctIn === 4'd0) else begin
            errors++; $error("FAIL rst_slct: got %0d, expected 0", DebugSlctIn);
        end
        #1;
        start = 1'b0;
        RESET = 1'b0;

        // Dump A: fixed boundary values plus random fill.
        for (int i = 0; i < NREG; i++) regs[i] = $urandom;
        regs[0]  = 32'h0000_0000;
        regs[1]  = 32'hDEAD_BEEF;
        regs[2]  = 32'h9A0F_F0A9;
        regs[15] = 32'hFFFF_FFFF;
        start_dump();
        finish_dump(1'b0, "A");
        compare_dump("A");
        got20 = '0;
        exp20 = '0;
        for (int k = 0; k < 20; k++) begin
            got20 = {got20[151:0], (k < rx_q.size()) ? rx_q[k] : 8'h00};
            exp20 = {exp20[151:0], 8'(lit[k])};
        end
        checks++;
        assert (got20 === exp20) else begin
            errors++;
            $error("FAIL A_first_two_lines: got %h, expected %h", got20, exp20);
        end

        // Dump B: start spammed while busy, read port scrambled during SEND.
        for (int i = 0; i < NREG; i++) regs[i] = $urandom;
        scr_en = 1'b1;
        start_dump();
        finish_dump(1'b1, "B");
        scr_en = 1'b0;
        compare_dump("B");

        // Dump C: reset in the middle of register 5, then a clean restart.
        for (int i = 0; i < NREG; i++) regs[i] = $urandom;
        start_dump();
        budget = 0;
        while (started < 53 && budget < 4000) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        assert (started >= 53) else begin
            errors++; $error("FAIL C_reach_reg5: got %0d frames, expected >= 53", started);
        end
        checks++;
        assert (DebugSlctIn === 4'd5) else begin
            errors++; $error("FAIL C_slct_reg5: got %0d, expected 5", DebugSlctIn);
        end
        repeat (6) @(negedge clk);
        #1 RESET = 1'b1;
        @(negedge clk);
        checks++;
        assert (tx === 1'b1 && busy === 1'b0 && DebugSlctIn === 4'd0 && done === 1'b0) else begin
            errors++;
            $error("FAIL C_abort: tx=%b busy=%b slct=%0d done=%b, expected 1 0 0 0",
                   tx, busy, DebugSlctIn, done);
        end
        #1 RESET = 1'b0;
        lows  = 0;
        dones = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (done !== 1'b0) dones++;
        end
        checks++;
        assert (lows === 0 && dones === 0) else begin
            errors++;
            $error("FAIL C_no_resume: got %0d low tx and %0d done cycles, expected 0 0", lows, dones);
        end
        start_dump();
        finish_dump(1'b0, "C");
        compare_dump("C");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
